// File: rtl/dnn_neuron3.sv
// Three-input fixed-point neuron: y = act(x1*w1 + x2*w2 + x3*w3 + BIAS), computed
// with one shared multiplier that is sequenced by a six-state FSM.
module dnn_neuron3 #(
    parameter int                 FRAC = 8,
    parameter logic signed [15:0] BIAS = 16'sh0000,
    parameter bit                 RELU = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic signed [15:0] x1,
    input  logic signed [15:0] x2,
    input  logic signed [15:0] x3,
    input  logic signed [15:0] w1,
    input  logic signed [15:0] w2,
    input  logic signed [15:0] w3,
    input  logic               done1,
    input  logic               done2,
    input  logic               done3,
    output logic signed [15:0] y,
    output logic               neuron_done,
    output logic               ready
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MUL1 = 3'd1,
        MUL2 = 3'd2,
        MUL3 = 3'd3,
        ACT  = 3'd4,
        DONE = 3'd5
    } state_t;

    state_t state, state_nxt;

    logic all_done;
    logic all_done_q;
    logic trigger;
    logic accept;

    logic signed [15:0] x1_p0, x2_p0, x3_p0;
    logic signed [15:0] w1_p0, w2_p0, w3_p0;
    logic signed [15:0] mul_a, mul_b;
    logic signed [31:0] prod;
    logic signed [33:0] prod_ext;
    logic signed [33:0] acc_p1;
    logic signed [33:0] bias_ext;
    logic signed [33:0] acc_shr;

    // Clamp the shifted accumulator into the 16-bit result range.
    function automatic logic signed [15:0] sat16(input logic signed [33:0] v);
        if (v > 34'sd32767)
            return 16'sh7FFF;
        else if (v < -34'sd32768)
            return 16'sh8000;
        else
            return v[15:0];
    endfunction

    function automatic logic signed [15:0] activate(input logic signed [15:0] v);
        if (RELU && v < 16'sd0)
            return 16'sh0000;
        else
            return v;
    endfunction

    assign all_done = done1 & done2 & done3;
    assign trigger  = all_done & ~all_done_q;
    assign ready    = (state == IDLE) || (state == DONE);
    assign accept   = trigger & ready;

    // Bias is aligned with the Q(2*FRAC) scale of the raw products.
    assign bias_ext = $signed({{18{BIAS[15]}}, BIAS}) <<< FRAC;
    assign acc_shr  = acc_p1 >>> FRAC;

    always_comb begin
        mul_a = x1_p0;
        mul_b = w1_p0;
        case (state)
            MUL2: begin
                mul_a = x2_p0;
                mul_b = w2_p0;
            end
            MUL3: begin
                mul_a = x3_p0;
                mul_b = w3_p0;
            end
            default: begin
                mul_a = x1_p0;
                mul_b = w1_p0;
            end
        endcase
    end

    assign prod     = mul_a * mul_b;
    assign prod_ext = $signed({{2{prod[31]}}, prod});

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = MUL1;
            MUL1:    state_nxt = MUL2;
            MUL2:    state_nxt = MUL3;
            MUL3:    state_nxt = ACT;
            ACT:     state_nxt = DONE;
            DONE:    if (accept) state_nxt = MUL1;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            all_done_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            all_done_q <= all_done;
        end
    end

    // Stage p0: operand capture on an accepted trigger
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x1_p0 <= '0;
            x2_p0 <= '0;
            x3_p0 <= '0;
            w1_p0 <= '0;
            w2_p0 <= '0;
            w3_p0 <= '0;
        end else if (accept) begin
            x1_p0 <= x1;
            x2_p0 <= x2;
            x3_p0 <= x3;
            w1_p0 <= w1;
            w2_p0 <= w2;
            w3_p0 <= w3;
        end
    end

    // Stage p1: accumulate one product per MUL state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_p1 <= '0;
        end else if (accept) begin
            acc_p1 <= bias_ext;
        end else if (state == MUL1 || state == MUL2 || state == MUL3) begin
            acc_p1 <= acc_p1 + prod_ext;
        end
    end

    // Stage p2: activation and result register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y           <= '0;
            neuron_done <= 1'b0;
        end else if (accept) begin
            neuron_done <= 1'b0;
        end else if (state == ACT) begin
            y           <= activate(sat16(acc_shr));
            neuron_done <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dnn_neuron3.sv
// Directed bench for dnn_neuron3: one instance with ReLU, one with identity activation.
module tb_dnn_neuron3;

    logic               clk;
    logic               rst_n;
    logic signed [15:0] x1, x2, x3, w1, w2, w3;
    logic               done1, done2, done3;
    logic signed [15:0] y_r, y_i;
    logic               nd_r, nd_i, rdy_r, rdy_i;

    int checks = 0;
    int errors = 0;

    dnn_neuron3 #(.FRAC(8), .BIAS(16'sh0000), .RELU(1'b1)) dut_relu (
        .clk(clk), .rst_n(rst_n),
        .x1(x1), .x2(x2), .x3(x3), .w1(w1), .w2(w2), .w3(w3),
        .done1(done1), .done2(done2), .done3(done3),
        .y(y_r), .neuron_done(nd_r), .ready(rdy_r)
    );

    dnn_neuron3 #(.FRAC(8), .BIAS(16'sh0000), .RELU(1'b0)) dut_id (
        .clk(clk), .rst_n(rst_n),
        .x1(x1), .x2(x2), .x3(x3), .w1(w1), .w2(w2), .w3(w3),
        .done1(done1), .done2(done2), .done3(done3),
        .y(y_i), .neuron_done(nd_i), .ready(rdy_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input logic [15:0] a1, b1, a2, b2, a3, b3);
        x1 = a1; w1 = b1; x2 = a2; w2 = b2; x3 = a3; w3 = b3;
    endtask

    task automatic set_done(input logic v);
        done1 = v; done2 = v; done3 = v;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_done(1'b0);
        set_ops(16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        tick();
        tick();
        checks++;
        if (y_r !== 16'h0000 || y_i !== 16'h0000) begin
            errors++;
            $display("FAIL reset_y: got %h/%h expected 0000", y_r, y_i);
        end
        checks++;
        if (nd_r !== 1'b0 || rdy_r !== 1'b1 || nd_i !== 1'b0 || rdy_i !== 1'b1) begin
            errors++;
            $display("FAIL reset_flags: nd=%b/%b rdy=%b/%b expected nd=0 rdy=1", nd_r, nd_i, rdy_r, rdy_i);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic_mac();
        set_ops(16'h0100, 16'h0200, 16'h0180, 16'h0100, 16'h0080, 16'hFF00);
        set_done(1'b1);
        tick();  // trigger edge T
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (rdy_r !== 1'b0 || nd_r !== 1'b0) begin
                errors++;
                $display("FAIL basic_busy[%0d]: rdy=%b nd=%b expected 0 0", k, rdy_r, nd_r);
            end
            tick();
        end
        checks++;
        if (y_r !== 16'h0300 || nd_r !== 1'b1 || rdy_r !== 1'b1) begin
            errors++;
            $display("FAIL basic_result: y=%h nd=%b rdy=%b expected 0300 1 1", y_r, nd_r, rdy_r);
        end
        checks++;
        if (y_i !== 16'h0300) begin
            errors++;
            $display("FAIL basic_result_id: y=%h expected 0300", y_i);
        end
    endtask

    task automatic test_relu();
        set_done(1'b0);
        tick();
        set_ops(16'h0100, 16'hFD00, 16'h0, 16'h0, 16'h0, 16'h0);
        set_done(1'b1);
        for (int k = 0; k < 5; k++) tick();
        checks++;
        if (y_r !== 16'h0000 || nd_r !== 1'b1) begin
            errors++;
            $display("FAIL relu_clamp: y=%h nd=%b expected 0000 1", y_r, nd_r);
        end
        checks++;
        if (y_i !== 16'hFD00 || nd_i !== 1'b1) begin
            errors++;
            $display("FAIL relu_identity: y=%h nd=%b expected fd00 1", y_i, nd_i);
        end
    endtask

    task automatic test_saturation();
        set_done(1'b0);
        tick();
        set_ops(16'h7F00, 16'h7F00, 16'h7F00, 16'h7F00, 16'h7F00, 16'h7F00);
        set_done(1'b1);
        for (int k = 0; k < 5; k++) tick();
        checks++;
        if (y_r !== 16'h7FFF || y_i !== 16'h7FFF) begin
            errors++;
            $display("FAIL sat_pos: y=%h/%h expected 7fff", y_r, y_i);
        end
        set_done(1'b0);
        tick();
        set_ops(16'h7F00, 16'h8100, 16'h7F00, 16'h8100, 16'h7F00, 16'h8100);
        set_done(1'b1);
        for (int k = 0; k < 5; k++) tick();
        checks++;
        if (y_i !== 16'h8000) begin
            errors++;
            $display("FAIL sat_neg: y=%h expected 8000", y_i);
        end
        checks++;
        if (y_r !== 16'h0000) begin
            errors++;
            $display("FAIL sat_neg_relu: y=%h expected 0000", y_r);
        end
    endtask

    task automatic test_no_retrigger();
        int bad;
        set_done(1'b0);
        tick();
        set_ops(16'h0100, 16'h0200, 16'h0180, 16'h0100, 16'h0080, 16'hFF00);
        set_done(1'b1);
        for (int k = 0; k < 5; k++) tick();
        checks++;
        if (y_r !== 16'h0300 || nd_r !== 1'b1) begin
            errors++;
            $display("FAIL hold_first: y=%h nd=%b expected 0300 1", y_r, nd_r);
        end
        set_ops(16'h0100, 16'hFD00, 16'h0, 16'h0, 16'h0, 16'h0);
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (y_i !== 16'h0300 || nd_i !== 1'b1 || rdy_i !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL hold_stable: %0d cycles deviated, expected 0 (y=%h nd=%b rdy=%b)", bad, y_i, nd_i, rdy_i);
        end
        done3 = 1'b0;
        tick();
        set_ops(16'h0200, 16'h0200, 16'h0, 16'h0, 16'h0, 16'h0);
        done3 = 1'b1;
        tick();  // trigger edge T
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            if (nd_i !== 1'b0 || rdy_i !== 1'b0) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL rerun_busy: %0d cycles with nd/rdy high, expected 0", bad);
        end
        checks++;
        if (y_i !== 16'h0400 || nd_i !== 1'b1) begin
            errors++;
            $display("FAIL rerun_result: y=%h nd=%b expected 0400 1", y_i, nd_i);
        end
    endtask

    task automatic test_busy_trigger();
        int bad;
        set_done(1'b0);
        tick();
        set_ops(16'h0100, 16'h0200, 16'h0180, 16'h0100, 16'h0080, 16'hFF00);
        set_done(1'b1);
        tick();          // T: MUL1
        tick();          // T+1: MUL2
        done3 = 1'b0;
        set_ops(16'h0100, 16'hFD00, 16'h0, 16'h0, 16'h0, 16'h0);
        tick();          // T+2: MUL3
        done3 = 1'b1;
        tick();          // T+3: ACT, rising edge seen while busy
        tick();          // T+4: result
        checks++;
        if (y_i !== 16'h0300 || nd_i !== 1'b1) begin
            errors++;
            $display("FAIL busy_result: y=%h nd=%b expected 0300 1", y_i, nd_i);
        end
        bad = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (y_i !== 16'h0300 || nd_i !== 1'b1 || rdy_i !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL busy_no_second_run: %0d cycles deviated, expected 0", bad);
        end
    endtask

    task automatic test_async_reset();
        set_done(1'b0);
        tick();
        set_ops(16'h0100, 16'h0200, 16'h0180, 16'h0100, 16'h0080, 16'hFF00);
        set_done(1'b1);
        tick();          // T
        tick();          // T+1: MUL2
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (y_r !== 16'h0000 || nd_r !== 1'b0 || rdy_r !== 1'b1) begin
            errors++;
            $display("FAIL areset_immediate: y=%h nd=%b rdy=%b expected 0000 0 1", y_r, nd_r, rdy_r);
        end
        set_done(1'b0);
        #7;
        rst_n = 1'b1;
        tick();
        set_ops(16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100);
        set_done(1'b1);
        for (int k = 0; k < 5; k++) tick();
        checks++;
        if (y_r !== 16'h0300 || nd_r !== 1'b1 || rdy_r !== 1'b1) begin
            errors++;
            $display("FAIL areset_recover: y=%h nd=%b rdy=%b expected 0300 1 1", y_r, nd_r, rdy_r);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        set_done(1'b0);
        set_ops(16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        test_reset();
        test_basic_mac();
        test_relu();
        test_saturation();
        test_no_retrigger();
        test_busy_trigger();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
